// File: rtl/uart_pkg.sv
// UART shared types and constants.
// TX state encoding, LCR view and word-length helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  localparam int OSR_DEFAULT = 16;

  typedef struct packed {
    logic [1:0] wls;
    logic       stb;
    logic       pen;
    logic       eps;
    logic       sp;
  } csr_t;

  function automatic logic [3:0] wls_bits(
    input logic [1:0] wls
  );
    return 4'd5 + {2'b00, wls};
  endfunction

endpackage

// File: rtl/uart_parity_gen.sv
// UART parity bit generator.
// Masks bits above word length before the XOR.
module uart_parity_gen
  import uart_pkg::*;
(
  input  logic [7:0] data,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  output logic       parity
);

  logic [7:0] mask;
  logic       x;

  // Select which data bits take part in the XOR.
  always_comb begin
    mask = 8'hff;
    unique case (1'b1)
      (wls == WLS_5): mask = 8'h1f;
      (wls == WLS_6): mask = 8'h3f;
      (wls == WLS_7): mask = 8'h7f;
      (wls == WLS_8): mask = 8'hff;
    endcase
  end

  // Stick parity overrides; otherwise even/odd.
  always_comb begin
    x = ^(data & mask);
    parity = 1'b0;
    if (pen) begin
      if (sp)
        parity = ~eps;
      else
        parity = eps ? x : ~x;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO pop, framing, parity, break.
// Frame format is frozen at the pop that starts a frame.
module uart_tx
  import uart_pkg::*;
#(
  parameter int OSR = OSR_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_pulse,
  input  logic       tx_fifo_empty_i,
  input  logic [7:0] tx_fifo_dout_i,
  output logic       tx_pop_o,
  input  logic [1:0] lcr_wls_i,
  input  logic       lcr_stb_i,
  input  logic       lcr_pen_i,
  input  logic       lcr_eps_i,
  input  logic       lcr_sp_i,
  input  logic       lcr_bc_i,
  output logic       tx_o,
  output logic       tx_busy_o
);

  localparam int CW = $clog2(2 * OSR + 1);

  localparam logic [CW-1:0] BIT_LAST =
    CW'(OSR - 1);
  localparam logic [CW-1:0] STOP15_LAST =
    CW'((3 * OSR) / 2 - 1);
  localparam logic [CW-1:0] STOP2_LAST =
    CW'(2 * OSR - 1);

  tx_state_t     state_q;
  tx_state_t     state_d;
  logic [CW-1:0] tick_q;
  logic [CW-1:0] tick_d;
  logic [2:0]    bit_q;
  logic [2:0]    bit_d;
  logic [7:0]    data_q;
  csr_t          csr_q;
  logic [CW-1:0] len_last;
  logic          tick_last;
  logic          bit_last;
  logic          par;
  logic          tx_d;
  logic          pop_d;
  logic          busy_d;

  uart_parity_gen u_par (
    .data   (data_q),
    .wls    (csr_q.wls),
    .pen    (csr_q.pen),
    .eps    (csr_q.eps),
    .sp     (csr_q.sp),
    .parity (par)
  );

  // Length of the current bit in ticks, minus one.
  always_comb begin
    len_last = BIT_LAST;
    if (state_q == STOP && csr_q.stb) begin
      if (csr_q.wls == WLS_5)
        len_last = STOP15_LAST;
      else
        len_last = STOP2_LAST;
    end
    tick_last = baud_pulse &&
                (tick_q == len_last);
    bit_last = ({1'b0, bit_q} ==
                (wls_bits(csr_q.wls) - 4'd1));
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
    end
  end

  // Next state and counters; ticks move only on baud_pulse.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    if (state_q != IDLE && baud_pulse)
      tick_d = tick_last ? '0 : tick_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (tx_pop_o) begin
          state_d = START;
          tick_d  = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (tick_last)
          state_d = DATA;
      end
      DATA: begin
        if (tick_last) begin
          if (bit_last) begin
            bit_d   = '0;
            state_d = csr_q.pen ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick_last)
          state_d = STOP;
      end
      STOP: begin
        if (tick_last)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs derived from the next state, then registered.
  always_comb begin
    pop_d  = (state_d == IDLE) &&
             !tx_fifo_empty_i && !tx_pop_o;
    busy_d = (state_d != IDLE);
    tx_d   = 1'b1;
    unique case (1'b1)
      (state_d == START):  tx_d = 1'b0;
      (state_d == DATA):   tx_d = data_q[bit_d];
      (state_d == PARITY): tx_d = par;
      default:             tx_d = 1'b1;
    endcase
    if (lcr_bc_i)
      tx_d = 1'b0;
  end

  // Registered outputs; reset forces the line high at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_o      <= 1'b1;
      tx_pop_o  <= 1'b0;
      tx_busy_o <= 1'b0;
    end else begin
      tx_o      <= tx_d;
      tx_pop_o  <= pop_d;
      tx_busy_o <= busy_d;
    end
  end

  // Capture data and frame format as the FIFO word is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      csr_q  <= '0;
    end else if (state_q == IDLE && tx_pop_o) begin
      data_q    <= tx_fifo_dout_i;
      csr_q.wls <= lcr_wls_i;
      csr_q.stb <= lcr_stb_i;
      csr_q.pen <= lcr_pen_i;
      csr_q.eps <= lcr_eps_i;
      csr_q.sp  <= lcr_sp_i;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx.
// Table-driven frames plus directed corner sequences.
module tb_uart_tx;
  import uart_pkg::*;

  localparam int OSR = 16;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  wls;
    logic        stb;
    logic        pen;
    logic        eps;
    logic        sp;
    logic [11:0] bits;
    int          nbits;
    int          stop_t;
    string       name;
  } vec_t;

  logic clk = 0;
  logic rst = 1;
  logic baud_pulse = 0;
  logic baud_en = 1;
  logic fifo_empty = 1;
  logic [7:0] fifo_dout = 0;
  logic tx_pop;
  logic [1:0] wls = 2'b11;
  logic stb = 0;
  logic pen = 0;
  logic eps = 0;
  logic sp = 0;
  logic bc = 0;
  logic tx;
  logic busy;

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int pop_bad = 0;
  logic ticks[$];
  logic [7:0] fifo[$];
  vec_t vecs[6];

  always #5 clk = ~clk;

  always @(posedge clk)
    baud_pulse <= baud_en && !baud_pulse;

  always @(posedge clk) begin
    if (tx_pop && fifo.size() > 0)
      void'(fifo.pop_front());
    fifo_empty <= (fifo.size() == 0);
    fifo_dout <= (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  always @(negedge clk) begin
    if (busy && baud_pulse)
      ticks.push_back(tx);
    if (tx_pop)
      pops++;
    if (tx_pop && fifo_empty)
      pop_bad++;
  end

  uart_tx #(.OSR(OSR)) dut (
    .clk             (clk),
    .rst             (rst),
    .baud_pulse      (baud_pulse),
    .tx_fifo_empty_i (fifo_empty),
    .tx_fifo_dout_i  (fifo_dout),
    .tx_pop_o        (tx_pop),
    .lcr_wls_i       (wls),
    .lcr_stb_i       (stb),
    .lcr_pen_i       (pen),
    .lcr_eps_i       (eps),
    .lcr_sp_i        (sp),
    .lcr_bc_i        (bc),
    .tx_o            (tx),
    .tx_busy_o       (busy)
  );

  task automatic chk(input string name,
                     input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic chk_le(input string name,
                        input int act,
                        input int lim);
    checks++;
    if (act > lim) begin
      errors++;
      $display("FAIL %s: got %0d expected <= %0d",
               name, act, lim);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    bit seen;
    while (!busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    seen = busy;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    chk({name, " done"},
        int'(seen && n < 4000), 1);
  endtask

  task automatic check_frame(input string name,
                             input int off,
                             input logic [11:0] bits,
                             input int nbits,
                             input int stop_t);
    int bad = 0;
    int idx;
    for (int i = 0; i < nbits; i++)
      for (int k = 0; k < OSR; k++) begin
        idx = off + i * OSR + k;
        if (idx >= ticks.size())
          bad++;
        else if (ticks[idx] !== bits[i])
          bad++;
      end
    chk({name, " bits"}, bad, 0);
    bad = 0;
    for (int k = 0; k < stop_t; k++) begin
      idx = off + nbits * OSR + k;
      if (idx >= ticks.size())
        bad++;
      else if (ticks[idx] !== 1'b1)
        bad++;
    end
    chk({name, " stop"}, bad, 0);
  endtask

  task automatic set_lcr(input vec_t v);
    wls = v.wls;
    stb = v.stb;
    pen = v.pen;
    eps = v.eps;
    sp  = v.sp;
  endtask

  task automatic run_vec(input vec_t v);
    int off;
    int p0;
    @(negedge clk);
    set_lcr(v);
    off = ticks.size();
    p0 = pops;
    fifo.push_back(v.data);
    wait_idle(v.name);
    chk({v.name, " len"}, ticks.size() - off,
        v.nbits * OSR + v.stop_t);
    check_frame(v.name, off, v.bits,
                v.nbits, v.stop_t);
    chk({v.name, " pops"}, pops - p0, 1);
  endtask

  task automatic wait_ticks(input int off,
                            input int cnt);
    int n = 0;
    while (ticks.size() - off < cnt && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("tick wait", int'(n < 2000), 1);
  endtask

  initial begin
    vec_t v;
    int off;
    int p0;
    int gap;
    int sz;
    int bad;
    logic tx_s;

    vecs[0] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0,
                {3'b000, 8'hA5, 1'b0},
                9, 16, "8N1"};
    vecs[1] = '{8'h35, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0,
                {3'b000, 1'b0, 7'h35, 1'b0},
                9, 16, "7E1"};
    vecs[2] = '{8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1,
                {5'b0, 1'b1, 5'h1F, 1'b0},
                7, 24, "5M1.5"};
    vecs[3] = '{8'h43, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0,
                {4'b0, 1'b1, 6'h03, 1'b0},
                8, 32, "6O2"};
    vecs[4] = '{8'h2A, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0,
                {6'b0, 5'h0A, 1'b0},
                6, 24, "5N1.5"};
    vecs[5] = '{8'hFF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1,
                {2'b0, 1'b0, 8'hFF, 1'b0},
                10, 16, "8S1"};

    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx", int'(tx), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset pop", int'(tx_pop), 0);
    @(negedge clk);
    rst = 0;

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i]);

    // Back-to-back 8N2 frames
    @(negedge clk);
    wls = 2'b11; stb = 1; pen = 0;
    off = ticks.size();
    p0 = pops;
    fifo.push_back(8'h01);
    fifo.push_back(8'h02);
    wait_idle("b2b first");
    gap = 1;
    while (!busy && gap < 20) begin
      @(negedge clk);
      if (!busy) gap++;
    end
    chk_le("b2b gap", gap, 2);
    wait_idle("b2b second");
    chk("b2b len", ticks.size() - off, 352);
    check_frame("b2b f1", off,
                {3'b000, 8'h01, 1'b0}, 9, 32);
    check_frame("b2b f2", off + 176,
                {3'b000, 8'h02, 1'b0}, 9, 32);
    chk("b2b pops", pops - p0, 2);

    // Baud freeze mid-frame
    @(negedge clk);
    wls = 2'b11; stb = 0; pen = 0;
    off = ticks.size();
    fifo.push_back(8'h0F);
    wait_ticks(off, 24);
    baud_en = 0;
    repeat (3) @(negedge clk);
    tx_s = tx;
    sz = ticks.size();
    repeat (100) @(negedge clk);
    chk("freeze busy", int'(busy), 1);
    chk("freeze tx", int'(tx), int'(tx_s));
    chk("freeze ticks", ticks.size(), sz);
    baud_en = 1;
    wait_idle("freeze");
    chk("freeze len", ticks.size() - off, 160);
    check_frame("freeze", off,
                {3'b000, 8'h0F, 1'b0}, 9, 16);

    // Break and LCR change mid-frame
    @(negedge clk);
    wls = 2'b11; stb = 0; pen = 0;
    off = ticks.size();
    fifo.push_back(8'hFF);
    wait_ticks(off, 36);
    bc = 1;
    wls = 2'b00; pen = 1; stb = 1;
    @(posedge clk);
    #1;
    chk("break on tx", int'(tx), 0);
    repeat (10) @(negedge clk);
    chk("break held tx", int'(tx), 0);
    bc = 0;
    @(posedge clk);
    #1;
    chk("break off tx", int'(tx), 1);
    @(negedge clk);
    wait_idle("break");
    chk("lcr change len", ticks.size() - off, 160);
    bad = 0;
    for (int k = 0; k < 16; k++)
      if (ticks[off + 144 + k] !== 1'b1) bad++;
    chk("break stop", bad, 0);

    // Reset during DATA bit 3
    @(negedge clk);
    wls = 2'b11; stb = 0; pen = 0;
    off = ticks.size();
    p0 = pops;
    fifo.push_back(8'h5A);
    wait_ticks(off, 70);
    rst = 1;
    @(posedge clk);
    #1;
    chk("mid rst tx", int'(tx), 1);
    chk("mid rst busy", int'(busy), 0);
    chk("mid rst pop", int'(tx_pop), 0);
    @(negedge clk);
    rst = 0;
    repeat (5) @(negedge clk);
    chk("mid rst pops", pops - p0, 1);
    chk("mid rst idle", int'(busy), 0);
    run_vec('{8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0,
              {3'b000, 8'h3C, 1'b0},
              9, 16, "after rst"});

    chk("pop when empty", pop_bad, 0);

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
